decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register/operand width.
REQ-002 SHALL have parameter FWD_N, default 2, meaning number of forwarding channels; index 0 is the youngest producer.
REQ-003 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid (in, 1), in_ready (out, 1), inst_addr (in, 32) and inst_data (in, 32), meaning the instruction fetch handshake.
REQ-007 SHALL have ports reg_read_addr_1_o/2_o (out, REG_AW), reg_read_en_1_o/2_o (out, 1) and reg_data_1_i/2_i (in, DATA_W), meaning two combinational regfile read channels.
REQ-008 SHALL have ports fwd_en_i (in, FWD_N), fwd_pending_i (in, FWD_N), fwd_addr_i (in, FWD_N*REG_AW) and fwd_data_i (in, FWD_N*DATA_W), meaning the forwarding channels; pending=1 means the destination is known but the data is not yet available.
REQ-009 SHALL have port flush_i  in  1  meaning discard the held and incoming instruction.
REQ-010 SHALL have ports out_valid (out, 1) and out_ready (in, 1), meaning the ID/EX handshake.
REQ-011 SHALL have registered outputs alu_op_o, alu_sel_o (widths per the opcode header), operand_1_o/2_o (DATA_W), reg_write_addr_o (REG_AW), reg_write_en_o (1), inst_addr_o (32) and inst_valid_o (1).

Function
REQ-012 SHALL decode SPECIAL (op 000000, sa 00000): OR, AND, XOR, NOR, SLLV, SRLV, SRAV, MOVN, MOVZ, with rd as destination and both reads enabled.
REQ-013 SHALL decode SLL, SRL and SRA when inst_data[31:21]=0, with read 2 only and operand_1 equal to zero-extended sa.
REQ-014 SHALL decode ORI, ANDI and XORI with a zero-extended imm16, and LUI with {imm16,16'h0}; rt is the destination, read 1 only, and operand_2 is the immediate.
REQ-015 SHALL, for any other encoding, output inst_valid_o=0, reg_write_en_o=0 and alu_op/alu_sel=NOP; out_valid still asserts.
REQ-016 SHALL resolve each enabled read source by taking the lowest-index channel with fwd_en=1 and a matching address; if there is no match, the source is the regfile.
REQ-017 SHALL resolve a read of register 0 to 0, never forwarded and never stalled.
REQ-018 SHALL define a hazard as: the first matching channel of any enabled nonzero read has fwd_pending_i=1.
REQ-019 SHALL drive in_ready = !hazard && !flush_i && (!out_valid || out_ready).
REQ-020 SHALL capture the decoded fields into the output registers and set out_valid=1 on in_valid && in_ready.
REQ-021 SHALL clear out_valid on an out_valid && out_ready cycle with no capture.
REQ-022 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-023 SHALL set reg_write_en_o for MOVN iff the resolved operand_2 != 0, and for MOVZ iff it == 0.
REQ-024 SHALL give one cycle of latency from acceptance to out_valid.
REQ-025 SHALL have a hazard persist with no capture, with out_valid dropping after a downstream handshake (bubble insertion).
REQ-026 SHALL clear out_valid on the next edge when flush_i=1; flush overrides a simultaneous accept.

Reset
REQ-027 SHALL, on rst=1 at an edge, clear out_valid, alu_op_o/alu_sel_o (to NOP), operands, reg_write_addr_o, reg_write_en_o, inst_addr_o, inst_valid_o and the stall counter to 0.
REQ-028 SHALL hold in_ready=0 while rst=1, and drop any instruction in flight when reset arrives mid-operation.

Configuration
REQ-029 SHALL gate a stall counter behind the macro DECODE_STALL_CNT_EN.
REQ-030 SHALL, when DECODE_STALL_CNT_EN is defined, provide output stall_cnt_o (16 bits) that increments on each cycle with in_valid && hazard, saturates at 16'hFFFF and is cleared by reset or flush_i.
REQ-031 SHALL, when DECODE_STALL_CNT_EN is undefined, omit the port stall_cnt_o and the counter.

Verification
REQ-032 SHALL cover: ORI r2,r1,0x00FF with r1=0x12340000 and no forwarding -> next cycle operand_1=0x12340000, operand_2=0x000000FF, write addr 2, write_en=1.
REQ-033 SHALL cover: OR r3,r1,r2 with fwd0={en,addr1,0xAAAA0000} and fwd1={en,addr1,0x5555} -> operand_1=0xAAAA0000 (channel 0 wins).
REQ-034 SHALL cover: fwd0 pending on r1 for 3 cycles with in_valid=1 -> in_ready=0 for 3 cycles, one bubble out, and stall_cnt_o=3 when enabled.
REQ-035 SHALL cover: MOVN r4,r5,r6 with r6=0, then with r6=7 -> reg_write_en_o=0, then 1.
REQ-036 SHALL cover: out_ready=0 for 4 cycles with out_valid=1 -> outputs constant and in_ready=0; flush_i on the 5th cycle -> out_valid=0 on the next edge.
REQ-037 SHALL cover: a read of r0 with fwd0={en,pending,addr 0} -> no stall, operand=0; and op 6'b111111 -> inst_valid_o=0, write_en=0.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS-subset decode stage: decodes logic/shift/move/immediate ops, resolves
// operands through regfile or forwarding, stalls on pending producers.
// Optional stall counter (stall_cnt_o) is built when DECODE_STALL_CNT_EN is defined.

module decode_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int FWD_N  = 2,
  parameter int REG_AW = 5
) (
  input  logic                    rd_en,
  input  logic [REG_AW-1:0]       rd_addr,
  input  logic [DATA_W-1:0]       rf_data,
  input  logic [FWD_N-1:0]        fwd_en,
  input  logic [FWD_N-1:0]        fwd_pending,
  input  logic [FWD_N*REG_AW-1:0] fwd_addr,
  input  logic [FWD_N*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]       data,
  output logic                    stall
);
  logic              hit, pend;
  logic [DATA_W-1:0] fdata;

  always_comb begin
    hit   = 1'b0;
    pend  = 1'b0;
    fdata = '0;
    // Walk from oldest to youngest so the lowest matching index wins.
    for (int i = FWD_N-1; i >= 0; i--) begin
      if (fwd_en[i] && fwd_addr[i*REG_AW +: REG_AW] == rd_addr) begin
        hit   = 1'b1;
        pend  = fwd_pending[i];
        fdata = fwd_data[i*DATA_W +: DATA_W];
      end
    end
    data  = '0;
    stall = 1'b0;
    if (rd_en && rd_addr != '0) begin
      data  = hit ? fdata : rf_data;
      stall = hit && pend;
    end
  end
endmodule

module decode_stage #(
  parameter int DATA_W = 32,
  parameter int FWD_N  = 2,
  parameter int REG_AW = 5
) (
`ifdef DECODE_STALL_CNT_EN
  output logic [15:0]             stall_cnt_o,
`endif
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             inst_addr,
  input  logic [31:0]             inst_data,
  output logic [REG_AW-1:0]       reg_read_addr_1_o,
  output logic [REG_AW-1:0]       reg_read_addr_2_o,
  output logic                    reg_read_en_1_o,
  output logic                    reg_read_en_2_o,
  input  logic [DATA_W-1:0]       reg_data_1_i,
  input  logic [DATA_W-1:0]       reg_data_2_i,
  input  logic [FWD_N-1:0]        fwd_en_i,
  input  logic [FWD_N-1:0]        fwd_pending_i,
  input  logic [FWD_N*REG_AW-1:0] fwd_addr_i,
  input  logic [FWD_N*DATA_W-1:0] fwd_data_i,
  input  logic                    flush_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              alu_op_o,
  output logic [2:0]              alu_sel_o,
  output logic [DATA_W-1:0]       operand_1_o,
  output logic [DATA_W-1:0]       operand_2_o,
  output logic [REG_AW-1:0]       reg_write_addr_o,
  output logic                    reg_write_en_o,
  output logic [31:0]             inst_addr_o,
  output logic                    inst_valid_o
);
  localparam logic [7:0] OP_NOP  = 8'b00000000;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_MOVZ = 8'b00001010;
  localparam logic [7:0] OP_MOVN = 8'b00001011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  typedef struct packed {
    logic [7:0]        alu_op;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [REG_AW-1:0] waddr;
    logic              wen;
    logic [31:0]       iaddr;
    logic              ivalid;
  } dec_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;

  assign op    = inst_data[31:26];
  assign rs    = inst_data[25:21];
  assign rt    = inst_data[20:16];
  assign rd    = inst_data[15:11];
  assign sa    = inst_data[10:6];
  assign funct = inst_data[5:0];
  assign imm   = inst_data[15:0];

  logic [7:0]        d_op;
  logic [2:0]        d_sel;
  logic              re1, re2, d_wen, d_iv, use_imm, use_sa, is_movn, is_movz;
  logic [REG_AW-1:0] d_wa;
  logic [31:0]       imm32;

  always_comb begin
    d_op    = OP_NOP;
    d_sel   = SEL_NOP;
    re1     = 1'b0;
    re2     = 1'b0;
    d_wa    = '0;
    d_wen   = 1'b0;
    d_iv    = 1'b0;
    use_imm = 1'b0;
    use_sa  = 1'b0;
    is_movn = 1'b0;
    is_movz = 1'b0;
    imm32   = '0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100101, 6'b100100, 6'b100110, 6'b100111,
          6'b000100, 6'b000110, 6'b000111, 6'b001011, 6'b001010: begin
            if (sa == 5'd0) begin
              re1 = 1'b1; re2 = 1'b1; d_wa = REG_AW'(rd); d_wen = 1'b1; d_iv = 1'b1;
              case (funct)
                6'b100101: begin d_op = OP_OR;  d_sel = SEL_LOGIC; end
                6'b100100: begin d_op = OP_AND; d_sel = SEL_LOGIC; end
                6'b100110: begin d_op = OP_XOR; d_sel = SEL_LOGIC; end
                6'b100111: begin d_op = OP_NOR; d_sel = SEL_LOGIC; end
                6'b000100: begin d_op = OP_SLL; d_sel = SEL_SHIFT; end
                6'b000110: begin d_op = OP_SRL; d_sel = SEL_SHIFT; end
                6'b000111: begin d_op = OP_SRA; d_sel = SEL_SHIFT; end
                6'b001011: begin d_op = OP_MOVN; d_sel = SEL_MOVE; is_movn = 1'b1; end
                default:   begin d_op = OP_MOVZ; d_sel = SEL_MOVE; is_movz = 1'b1; end
              endcase
            end
          end
          6'b000000, 6'b000010, 6'b000011: begin
            // Immediate shifts: rs field must be zero, shift amount comes from sa.
            if (rs == 5'd0) begin
              re2 = 1'b1; use_sa = 1'b1; d_wa = REG_AW'(rd); d_wen = 1'b1; d_iv = 1'b1;
              d_sel = SEL_SHIFT;
              case (funct)
                6'b000000: d_op = OP_SLL;
                6'b000010: d_op = OP_SRL;
                default:   d_op = OP_SRA;
              endcase
            end
          end
          default: ;
        endcase
      end
      6'b001101, 6'b001100, 6'b001110, 6'b001111: begin
        re1 = 1'b1; use_imm = 1'b1; d_wa = REG_AW'(rt); d_wen = 1'b1; d_iv = 1'b1;
        d_sel = SEL_LOGIC;
        imm32 = {16'h0, imm};
        case (op)
          6'b001101: d_op = OP_OR;
          6'b001100: d_op = OP_AND;
          6'b001110: d_op = OP_XOR;
          default: begin d_op = OP_OR; imm32 = {imm, 16'h0}; end
        endcase
      end
      default: ;
    endcase
  end

  assign reg_read_addr_1_o = REG_AW'(rs);
  assign reg_read_addr_2_o = REG_AW'(rt);
  assign reg_read_en_1_o   = re1 && in_valid;
  assign reg_read_en_2_o   = re2 && in_valid;

  logic [1:0]             rd_en, rd_stall;
  logic [1:0][REG_AW-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rf_data, rd_data;

  assign rd_en   = {reg_read_en_2_o, reg_read_en_1_o};
  assign rd_addr = {reg_read_addr_2_o, reg_read_addr_1_o};
  assign rf_data = {reg_data_2_i, reg_data_1_i};

  for (genvar g = 0; g < 2; g++) begin : g_rd
    decode_fwd_mux #(.DATA_W(DATA_W), .FWD_N(FWD_N), .REG_AW(REG_AW)) u_mux (
      .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rf_data(rf_data[g]),
      .fwd_en(fwd_en_i), .fwd_pending(fwd_pending_i),
      .fwd_addr(fwd_addr_i), .fwd_data(fwd_data_i),
      .data(rd_data[g]), .stall(rd_stall[g])
    );
  end

  logic hazard;
  dec_t dec, out_q;

  assign hazard = |rd_stall;

  always_comb begin
    dec.alu_op = d_op;
    dec.alu_sel = d_sel;
    dec.op1    = use_sa ? DATA_W'(sa) : rd_data[0];
    dec.op2    = use_imm ? DATA_W'(imm32) : rd_data[1];
    dec.waddr  = d_wa;
    dec.wen    = is_movn ? (dec.op2 != '0) : is_movz ? (dec.op2 == '0) : d_wen;
    dec.iaddr  = inst_addr;
    dec.ivalid = d_iv;
  end

  assign in_ready = !rst && !hazard && !flush_i && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op_o         = out_q.alu_op;
  assign alu_sel_o        = out_q.alu_sel;
  assign operand_1_o      = out_q.op1;
  assign operand_2_o      = out_q.op2;
  assign reg_write_addr_o = out_q.waddr;
  assign reg_write_en_o   = out_q.wen;
  assign inst_addr_o      = out_q.iaddr;
  assign inst_valid_o     = out_q.ivalid;

`ifdef DECODE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || flush_i)
      stall_cnt_o <= '0;
    else if (in_valid && hazard && stall_cnt_o != 16'hFFFF)
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues hand-computed packets,
// a negedge monitor pops and compares on each output handshake.
module tb_decode_stage;
  localparam int DATA_W = 32, FWD_N = 2, REG_AW = 5;
  localparam logic [7:0] O_NOP = 8'h00, O_OR = 8'b00100101, O_AND = 8'b00100100,
    O_XOR = 8'b00100110, O_SLL = 8'b01111100, O_MOVN = 8'b00001011, O_MOVZ = 8'b00001010;
  localparam logic [2:0] S_NOP = 3'd0, S_LOGIC = 3'd1, S_SHIFT = 3'd2, S_MOVE = 3'd3;

  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] o1, o2;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] ia;
    logic        iv;
  } exp_t;

  logic clk, rst, in_valid, in_ready, flush_i, out_valid, out_ready;
  logic [31:0] inst_addr, inst_data;
  logic [REG_AW-1:0] reg_read_addr_1_o, reg_read_addr_2_o, reg_write_addr_o;
  logic reg_read_en_1_o, reg_read_en_2_o, reg_write_en_o, inst_valid_o;
  logic [DATA_W-1:0] reg_data_1_i, reg_data_2_i, operand_1_o, operand_2_o;
  logic [FWD_N-1:0] fwd_en_i, fwd_pending_i;
  logic [FWD_N*REG_AW-1:0] fwd_addr_i;
  logic [FWD_N*DATA_W-1:0] fwd_data_i;
  logic [7:0] alu_op_o;
  logic [2:0] alu_sel_o;
  logic [31:0] inst_addr_o;
`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  logic [31:0] rf [32];
  assign reg_data_1_i = rf[reg_read_addr_1_o];
  assign reg_data_2_i = rf[reg_read_addr_2_o];

  decode_stage #(.DATA_W(DATA_W), .FWD_N(FWD_N), .REG_AW(REG_AW)) dut (
`ifdef DECODE_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .reg_read_addr_1_o(reg_read_addr_1_o), .reg_read_addr_2_o(reg_read_addr_2_o),
    .reg_read_en_1_o(reg_read_en_1_o), .reg_read_en_2_o(reg_read_en_2_o),
    .reg_data_1_i(reg_data_1_i), .reg_data_2_i(reg_data_2_i),
    .fwd_en_i(fwd_en_i), .fwd_pending_i(fwd_pending_i),
    .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op_o(alu_op_o), .alu_sel_o(alu_sel_o),
    .operand_1_o(operand_1_o), .operand_2_o(operand_2_o),
    .reg_write_addr_o(reg_write_addr_o), .reg_write_en_o(reg_write_en_o),
    .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  exp_t  sb_q[$];
  string nm_q[$];

  function automatic exp_t mk(input logic [7:0] op, input logic [2:0] sel,
                              input logic [31:0] o1, o2, input logic [4:0] wa,
                              input logic we, input logic [31:0] ia, input logic iv);
    mk = '{op, sel, o1, o2, wa, we, ia, iv};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] ia, inst, input exp_t e, input string nm);
    bit acc = 1'b0;
    inst_addr = ia; inst_data = inst; in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) begin sb_q.push_back(e); nm_q.push_back(nm); end
      @(negedge clk);
    end
    in_valid = 1'b0; fwd_en_i = '0; fwd_pending_i = '0;
    if (!acc) begin n_cmp++; n_bad++; $display("FAIL %s accept_timeout act=0 exp=1", nm); end
  endtask

  exp_t  m_e, m_a;
  string m_nm;
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      m_a = '{alu_op_o, alu_sel_o, operand_1_o, operand_2_o, reg_write_addr_o,
              reg_write_en_o, inst_addr_o, inst_valid_o};
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out act=%h exp=none", m_a);
      end else begin
        m_e = sb_q.pop_front(); m_nm = nm_q.pop_front();
        if (m_a !== m_e) begin
          n_bad++;
          $display("FAIL %s act=%h exp=%h", m_nm, m_a, m_e);
        end
      end
    end
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'h12340000; rf[2] = 32'h000000F0; rf[5] = 32'h55; rf[6] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; inst_addr = '0; inst_data = '0; flush_i = 1'b0;
    out_ready = 1'b1; fwd_en_i = '0; fwd_pending_i = '0; fwd_addr_i = '0; fwd_data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_op", {24'd0, alu_op_o}, 32'd0);
    check("rst_operand_1", operand_1_o, 32'd0);
    check("rst_wen_iv", {30'd0, reg_write_en_o, inst_valid_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    send(32'h100, 32'h342200FF, mk(O_OR, S_LOGIC, 32'h12340000, 32'hFF, 5'd2, 1, 32'h100, 1), "ori");
    fwd_en_i = 2'b11; fwd_pending_i = 2'b00;
    fwd_addr_i = {5'd1, 5'd1}; fwd_data_i = {32'h00005555, 32'hAAAA0000};
    send(32'h104, 32'h00221825, mk(O_OR, S_LOGIC, 32'hAAAA0000, 32'hF0, 5'd3, 1, 32'h104, 1), "or_fwd_ch0");
    fwd_en_i = 2'b10; fwd_addr_i = {5'd2, 5'd0}; fwd_data_i = {32'h77, 32'h0};
    send(32'h108, 32'h00221824, mk(O_AND, S_LOGIC, 32'h12340000, 32'h77, 5'd3, 1, 32'h108, 1), "and_fwd_ch1");
    send(32'h10C, 32'h00A6200B, mk(O_MOVN, S_MOVE, 32'h55, 32'h0, 5'd4, 0, 32'h10C, 1), "movn_zero");
    rf[6] = 32'h7;
    send(32'h110, 32'h00A6200B, mk(O_MOVN, S_MOVE, 32'h55, 32'h7, 5'd4, 1, 32'h110, 1), "movn_nz");
    send(32'h114, 32'h00A6200A, mk(O_MOVZ, S_MOVE, 32'h55, 32'h7, 5'd4, 0, 32'h114, 1), "movz_nz");
    send(32'h118, 32'h00024100, mk(O_SLL, S_SHIFT, 32'h4, 32'hF0, 5'd8, 1, 32'h118, 1), "sll");
    send(32'h11C, 32'h3C09ABCD, mk(O_OR, S_LOGIC, 32'h0, 32'hABCD0000, 5'd9, 1, 32'h11C, 1), "lui");
    fwd_en_i = 2'b01; fwd_pending_i = 2'b01; fwd_addr_i = '0; fwd_data_i = {32'h0, 32'hDEAD};
    send(32'h120, 32'h340A0005, mk(O_OR, S_LOGIC, 32'h0, 32'h5, 5'd10, 1, 32'h120, 1), "r0_pending");
    send(32'h124, 32'hFC000000, mk(O_NOP, S_NOP, 32'h0, 32'h0, 5'd0, 0, 32'h124, 0), "illegal");

    // Producer on r1 pending for three cycles behind an XORI.
    send(32'h128, 32'h38071234, mk(O_XOR, S_LOGIC, 32'h0, 32'h1234, 5'd7, 1, 32'h128, 1), "xori");
    inst_addr = 32'h12C; inst_data = 32'h00221825; in_valid = 1'b1;
    fwd_en_i = 2'b01; fwd_pending_i = 2'b01; fwd_addr_i = {5'd0, 5'd1}; fwd_data_i = {32'h0, 32'hBEEF};
    for (int k = 0; k < 3; k++) begin
      #1 check("haz_in_ready", {31'd0, in_ready}, 32'd0);
      if (k > 0) check("haz_bubble", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
`ifdef DECODE_STALL_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt_o}, 32'd3);
`endif
    fwd_pending_i = 2'b00;
    send(32'h12C, 32'h00221825, mk(O_OR, S_LOGIC, 32'hBEEF, 32'hF0, 5'd3, 1, 32'h12C, 1), "or_after_haz");

    // Backpressure hold, then flush the held instruction.
    @(negedge clk); out_ready = 1'b0;
    e = mk(O_AND, S_LOGIC, 32'h12340000, 32'h0F0F, 5'd11, 1, 32'h130, 1);
    send(32'h130, 32'h302B0F0F, e, "andi_held");
    inst_addr = 32'h200; inst_data = 32'h38071234; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_op2", operand_2_o, e.o2);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    #1 check("flush_valid", {31'd0, out_valid}, 32'd0);
`ifdef DECODE_STALL_CNT_EN
    check("flush_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
`endif
    if (sb_q.size() > 0) begin void'(sb_q.pop_front()); void'(nm_q.pop_front()); end
    out_ready = 1'b1;
    check("flush_acc_ready", {31'd0, in_ready}, 32'd1);
    flush_i = 1'b1;
    #1 check("flush_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); flush_i = 1'b0; in_valid = 1'b0;
    #1 check("flush_no_capture", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    // Reset arriving with an instruction held.
    out_ready = 1'b0;
    send(32'h134, 32'h342200FF, mk(O_OR, S_LOGIC, 32'h12340000, 32'hFF, 5'd2, 1, 32'h134, 1), "ori_rst");
    rst = 1'b1;
    #1 check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_op1", operand_1_o, 32'd0);
    if (sb_q.size() > 0) begin void'(sb_q.pop_front()); void'(nm_q.pop_front()); end
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
